l0p_width_negotiator: RTL and testbench

L0P_WIDTH_NEGOTIATOR -- requirements
Module: l0p_width_negotiator

---
 rtl/l0p_width_negotiator.sv | 262 ++++++++++++++++++++++++++
 tb/tb_l0p_width_negotiator.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l0p_width_negotiator.sv
// L0p link-width negotiator.
// Runs local width-change requests as a request/response exchange of Link
// Management DLLPs, with per-attempt response timeout and bounded resends.
// It also answers width requests from the link partner. A high-priority remote
// request can pre-empt a low-priority local attempt that is waiting for its
// response.
//
// Ports
//   clk, rst                    rising-edge clock, asynchronous active-high reset
//   req_valid/req_width/
//   req_priority/req_ready      local width-change request handshake
//   max_width                   highest locally supported width code (0=x1 .. 4=x16)
//   tx_dllp_valid/data/ready    outbound DLLP, held stable until accepted
//   rx_dllp_valid/data          inbound DLLP, single-cycle strobe
//   cur_width                   currently negotiated width code
//   busy                        exchange in progress
//   done/done_status            completion pulse; status 00 OK, 01 NAK,
//                               10 TIMEOUT, 11 PREEMPT (held until next done)
module l0p_width_negotiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_width,
  input  logic        req_priority,
  output logic        req_ready,
  input  logic [2:0]  max_width,
  output logic        tx_dllp_valid,
  output logic [31:0] tx_dllp_data,
  input  logic        tx_dllp_ready,
  input  logic        rx_dllp_valid,
  input  logic [31:0] rx_dllp_data,
  output logic [2:0]  cur_width,
  output logic        busy,
  output logic        done,
  output logic [1:0]  done_status
);

  localparam int unsigned WIDTH_W = 3;
  localparam int unsigned DLLP_W  = 32;
  localparam int unsigned TMR_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [7:0]         DLLP_TYPE   = 8'h28;
  localparam logic [7:0]         DLLP_RSVD   = 8'h00;
  localparam logic [3:0]         CMD_REQ     = 4'h1;
  localparam logic [3:0]         CMD_RSP     = 4'h2;
  localparam logic [2:0]         PL_NONE     = 3'b000;
  localparam logic [2:0]         PL_ACK      = 3'b001;
  localparam logic [2:0]         PL_NAK      = 3'b010;
  localparam logic [WIDTH_W-1:0] WIDTH_X16   = 3'd4;
  localparam logic [1:0]         ST_OK       = 2'b00;
  localparam logic [1:0]         ST_NAK      = 2'b01;
  localparam logic [1:0]         ST_TIMEOUT  = 2'b10;
  localparam logic [1:0]         ST_PREEMPT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SEND_REQ,
    WAIT_RSP,
    SEND_RSP
  } state_e;

  // Assemble a Link Management DLLP.
  function automatic logic [DLLP_W-1:0] build_dllp(
    input logic               prio,
    input logic [3:0]         cmd,
    input logic [2:0]         payload,
    input logic [WIDTH_W-1:0] width
  );
    return {DLLP_TYPE, DLLP_RSVD, prio, cmd, payload, 5'd0, width};
  endfunction

  // A width is acceptable when it is a defined code and locally supported.
  function automatic logic width_ok(
    input logic [WIDTH_W-1:0] width,
    input logic [WIDTH_W-1:0] limit
  );
    return (width <= WIDTH_X16) && (width <= limit);
  endfunction

  // State and datapath registers.
  state_e               state_q,       state_d;
  logic [DLLP_W-1:0]    tx_data_q,     tx_data_d;
  logic [WIDTH_W-1:0]   lat_width_q,   lat_width_d;
  logic                 lat_prio_q,    lat_prio_d;
  logic [WIDTH_W-1:0]   rsp_width_q,   rsp_width_d;
  logic                 rsp_ack_q,     rsp_ack_d;
  logic [TMR_W-1:0]     timer_q,       timer_d;
  logic [RETRY_W-1:0]   retry_q,       retry_d;
  logic [WIDTH_W-1:0]   cur_width_q,   cur_width_d;
  logic                 done_q,        done_d;
  logic [1:0]           done_status_q, done_status_d;

  // Inbound DLLP decode.
  logic               rx_hdr_ok_c;
  logic [3:0]         rx_cmd_c;
  logic               rx_prio_c;
  logic [2:0]         rx_payload_c;
  logic [WIDTH_W-1:0] rx_width_c;
  logic               rx_req_c;
  logic               rx_rsp_c;
  logic               rx_rsp_match_c;
  logic               rx_ack_c;
  logic [DLLP_W-1:0]  rx_reply_c;
  logic [4:0]         unused_rsvd_c;

  assign rx_hdr_ok_c   = rx_dllp_valid
                         && (rx_dllp_data[31:24] == DLLP_TYPE)
                         && (rx_dllp_data[23:16] == DLLP_RSVD);
  assign rx_prio_c     = rx_dllp_data[15];
  assign rx_cmd_c      = rx_dllp_data[14:11];
  assign rx_payload_c  = rx_dllp_data[10:8];
  assign rx_width_c    = rx_dllp_data[2:0];
  assign unused_rsvd_c = rx_dllp_data[7:3];

  assign rx_req_c = rx_hdr_ok_c && (rx_cmd_c == CMD_REQ);
  assign rx_rsp_c = rx_hdr_ok_c && (rx_cmd_c == CMD_RSP);

  // Only an ACK/NAK for the width we asked for terminates the local attempt.
  assign rx_rsp_match_c = rx_rsp_c
                          && (rx_width_c == lat_width_q)
                          && ((rx_payload_c == PL_ACK) || (rx_payload_c == PL_NAK));

  // Reply to a remote request: echo its priority and width.
  assign rx_ack_c   = width_ok(rx_width_c, max_width);
  assign rx_reply_c = build_dllp(rx_prio_c, CMD_RSP,
                                 rx_ack_c ? PL_ACK : PL_NAK, rx_width_c);

  // A decoded remote request in IDLE wins over a same-cycle local request.
  assign req_ready     = (state_q == IDLE) && !rx_req_c;
  assign busy          = (state_q != IDLE);
  assign tx_dllp_valid = (state_q == SEND_REQ) || (state_q == SEND_RSP);
  assign tx_dllp_data  = tx_data_q;
  assign cur_width     = cur_width_q;
  assign done          = done_q;
  assign done_status   = done_status_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tx_data_q     <= '0;
      lat_width_q   <= '0;
      lat_prio_q    <= 1'b0;
      rsp_width_q   <= '0;
      rsp_ack_q     <= 1'b0;
      timer_q       <= '0;
      retry_q       <= '0;
      cur_width_q   <= '0;
      done_q        <= 1'b0;
      done_status_q <= ST_OK;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      lat_width_q   <= lat_width_d;
      lat_prio_q    <= lat_prio_d;
      rsp_width_q   <= rsp_width_d;
      rsp_ack_q     <= rsp_ack_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      cur_width_q   <= cur_width_d;
      done_q        <= done_d;
      done_status_q <= done_status_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    lat_width_d   = lat_width_q;
    lat_prio_d    = lat_prio_q;
    rsp_width_d   = rsp_width_q;
    rsp_ack_d     = rsp_ack_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    cur_width_d   = cur_width_q;
    done_d        = 1'b0;
    done_status_d = done_status_q;

    case (state_q)
      IDLE: begin
        if (rx_req_c) begin
          rsp_width_d = rx_width_c;
          rsp_ack_d   = rx_ack_c;
          tx_data_d   = rx_reply_c;
          state_d     = SEND_RSP;
        end else if (req_valid) begin
          if (!width_ok(req_width, max_width)) begin
            // Unsupported width is refused locally without touching the link.
            done_d        = 1'b1;
            done_status_d = ST_NAK;
          end else begin
            lat_width_d = req_width;
            lat_prio_d  = req_priority;
            retry_d     = '0;
            tx_data_d   = build_dllp(req_priority, CMD_REQ, PL_NONE, req_width);
            state_d     = SEND_REQ;
          end
        end
      end

      SEND_REQ: begin
        if (tx_dllp_ready) begin
          timer_d = TMR_W'(TIMEOUT_CYCLES - 1);
          state_d = WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        if (rx_rsp_match_c) begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (rx_payload_c == PL_ACK) begin
            cur_width_d   = lat_width_q;
            done_status_d = ST_OK;
          end else begin
            done_status_d = ST_NAK;
          end
        end else if (rx_req_c && rx_prio_c && !lat_prio_q) begin
          // High-priority remote request aborts our low-priority attempt.
          done_d        = 1'b1;
          done_status_d = ST_PREEMPT;
          rsp_width_d   = rx_width_c;
          rsp_ack_d     = rx_ack_c;
          tx_data_d     = rx_reply_c;
          state_d       = SEND_RSP;
        end else if (timer_q <= TMR_W'(1)) begin
          // Expiry lands exactly TIMEOUT_CYCLES after the request handshake.
          timer_d = '0;
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = SEND_REQ;
          end else begin
            done_d        = 1'b1;
            done_status_d = ST_TIMEOUT;
            state_d       = IDLE;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      SEND_RSP: begin
        if (tx_dllp_ready) begin
          if (rsp_ack_q) begin
            cur_width_d = rsp_width_q;
          end
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l0p_width_negotiator.sv
// Bench for l0p_width_negotiator: directed scenarios followed by a randomized
// sequence checked against a transaction-level expectation model.
module tb_l0p_width_negotiator;

  localparam int unsigned TMO = 16;
  localparam int unsigned RTY = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_width;
  logic        req_priority;
  logic        req_ready;
  logic [2:0]  max_width;
  logic        tx_dllp_valid;
  logic [31:0] tx_dllp_data;
  logic        tx_dllp_ready;
  logic        rx_dllp_valid;
  logic [31:0] rx_dllp_data;
  logic [2:0]  cur_width;
  logic        busy;
  logic        done;
  logic [1:0]  done_status;

  l0p_width_negotiator #(
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY     (RTY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_width    (req_width),
    .req_priority (req_priority),
    .req_ready    (req_ready),
    .max_width    (max_width),
    .tx_dllp_valid(tx_dllp_valid),
    .tx_dllp_data (tx_dllp_data),
    .tx_dllp_ready(tx_dllp_ready),
    .rx_dllp_valid(rx_dllp_valid),
    .rx_dllp_data (rx_dllp_data),
    .cur_width    (cur_width),
    .busy         (busy),
    .done         (done),
    .done_status  (done_status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Monitors: cycle count, accepted outbound DLLPs, done pulses.
  int          cyc = 0;
  int          tx_cyc_q[$];
  logic [31:0] tx_dat_q[$];
  int          done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && tx_dllp_valid && tx_dllp_ready) begin
      tx_cyc_q.push_back(cyc);
      tx_dat_q.push_back(tx_dllp_data);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected DLLP image straight from the wire format.
  function automatic logic [31:0] mk(input logic p, input logic [3:0] c,
                                     input logic [2:0] pl, input logic [2:0] w);
    return {8'h28, 8'h00, p, c, pl, 5'd0, w};
  endfunction

  function automatic logic legal(input int w, input int mx);
    return (w <= 4) && (w <= mx);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic local_req(input logic [2:0] w, input logic p);
    req_width    = w;
    req_priority = p;
    req_valid    = 1'b1;
    step();
    req_valid    = 1'b0;
  endtask

  task automatic rx_send(input logic [31:0] d);
    rx_dllp_valid = 1'b1;
    rx_dllp_data  = d;
    step();
    rx_dllp_valid = 1'b0;
    rx_dllp_data  = '0;
  endtask

  task automatic wait_tx(output logic [31:0] d, output logic got);
    got = 1'b0;
    d   = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (tx_dllp_valid && tx_dllp_ready) begin
        d   = tx_dllp_data;
        got = 1'b1;
      end
      step();
    end
  endtask

  task automatic wait_done(output logic [1:0] st, output logic got);
    got = 1'b0;
    st  = 2'bxx;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done) begin
        st  = done_status;
        got = 1'b1;
      end else begin
        step();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        got;
    logic [1:0]  st;
    int          n0, d0, kind, w, mx, r, exp_cur, exp_st;
    logic        p;

    rst           = 1'b1;
    req_valid     = 1'b0;
    req_width     = '0;
    req_priority  = 1'b0;
    max_width     = 3'd4;
    tx_dllp_ready = 1'b1;
    rx_dllp_valid = 1'b0;
    rx_dllp_data  = '0;
    repeat (3) step();

    // Reset state.
    chk("rst_cur_width", 32'(cur_width), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_status", 32'(done_status), 0);
    chk("rst_tx_valid", 32'(tx_dllp_valid), 0);
    rst = 1'b0;
    step();
    chk("idle_req_ready", 32'(req_ready), 1);

    // Basic ACKed local request, width x8.
    local_req(3'd3, 1'b0);
    chk("req_busy", 32'(busy), 1);
    chk("req_ready_busy", 32'(req_ready), 0);
    wait_tx(d, got);
    chk("basic_tx_seen", 32'(got), 1);
    chk("basic_tx_data", d, 32'h2800_0803);
    rx_send(mk(1'b0, 4'h2, 3'b001, 3'd3));
    wait_done(st, got);
    chk("basic_done_seen", 32'(got), 1);
    chk("basic_status", 32'(st), 0);
    chk("basic_cur_width", 32'(cur_width), 3);
    step();
    chk("done_single_pulse", 32'(done), 0);
    chk("basic_idle", 32'(busy), 0);

    // Locally refused widths: undefined code and above max_width.
    n0 = tx_dat_q.size();
    local_req(3'd5, 1'b0);
    wait_done(st, got);
    chk("bad5_done", 32'(got), 1);
    chk("bad5_status", 32'(st), 1);
    chk("bad5_busy", 32'(busy), 0);
    step();
    max_width = 3'd2;
    local_req(3'd3, 1'b1);
    wait_done(st, got);
    chk("overmax_done", 32'(got), 1);
    chk("overmax_status", 32'(st), 1);
    step();
    chk("refused_no_tx", 32'(tx_dat_q.size() - n0), 0);
    chk("refused_cur_width", 32'(cur_width), 3);
    max_width = 3'd4;

    // No response: first attempt plus RTY resends, TMO cycles apart.
    n0 = tx_dat_q.size();
    d0 = done_cnt;
    local_req(3'd2, 1'b0);
    wait_done(st, got);
    chk("tmo_done", 32'(got), 1);
    chk("tmo_status", 32'(st), 2);
    chk("tmo_tx_count", 32'(tx_dat_q.size() - n0), 32'(RTY + 1));
    if (tx_dat_q.size() >= n0 + 4) begin
      for (int k = 1; k < 4; k++) begin
        chk("tmo_gap", 32'(tx_cyc_q[n0+k] - tx_cyc_q[n0+k-1]), 32'(TMO));
        chk("tmo_resend_data", tx_dat_q[n0+k], mk(1'b0, 4'h1, 3'b000, 3'd2));
      end
    end
    chk("tmo_cur_width", 32'(cur_width), 3);
    step();
    chk("tmo_one_done", 32'(done_cnt - d0), 1);

    // Remote request for x16 while only x4 is supported -> NAK reply.
    max_width = 3'd2;
    d0 = done_cnt;
    rx_send(mk(1'b0, 4'h1, 3'b000, 3'd4));
    wait_tx(d, got);
    chk("rnak_tx_seen", 32'(got), 1);
    chk("rnak_tx_data", d, 32'h2800_1204);
    chk("rnak_cur_width", 32'(cur_width), 3);
    chk("rnak_no_done", 32'(done_cnt - d0), 0);
    max_width = 3'd4;

    // High-priority remote request pre-empts low-priority local wait.
    local_req(3'd2, 1'b0);
    wait_tx(d, got);
    chk("pre_req_data", d, 32'h2800_0802);
    step();
    rx_send(mk(1'b1, 4'h1, 3'b000, 3'd1));
    wait_done(st, got);
    chk("pre_done", 32'(got), 1);
    chk("pre_status", 32'(st), 3);
    wait_tx(d, got);
    chk("pre_tx_data", d, 32'h2800_9101);
    chk("pre_cur_width", 32'(cur_width), 1);

    // Remote request beats a simultaneous local request.
    n0 = tx_dat_q.size();
    d0 = done_cnt;
    req_width     = 3'd3;
    req_priority  = 1'b0;
    req_valid     = 1'b1;
    rx_dllp_valid = 1'b1;
    rx_dllp_data  = mk(1'b0, 4'h1, 3'b000, 3'd2);
    #1;
    chk("collide_req_ready", 32'(req_ready), 0);
    step();
    req_valid     = 1'b0;
    rx_dllp_valid = 1'b0;
    rx_dllp_data  = '0;
    wait_tx(d, got);
    chk("collide_tx_data", d, mk(1'b0, 4'h2, 3'b001, 3'd2));
    repeat (3) step();
    chk("collide_tx_count", 32'(tx_dat_q.size() - n0), 1);
    chk("collide_no_done", 32'(done_cnt - d0), 0);
    chk("collide_cur_width", 32'(cur_width), 2);

    // High-priority local attempt is not pre-empted.
    local_req(3'd4, 1'b1);
    wait_tx(d, got);
    d0 = done_cnt;
    rx_send(mk(1'b1, 4'h1, 3'b000, 3'd1));
    chk("nopre_busy", 32'(busy), 1);
    chk("nopre_no_done", 32'(done_cnt - d0), 0);
    rx_send(mk(1'b0, 4'h2, 3'b001, 3'd4));
    wait_done(st, got);
    chk("nopre_status", 32'(st), 0);
    chk("nopre_cur_width", 32'(cur_width), 4);

    // Mismatched-width response ignored, then NAK.
    local_req(3'd1, 1'b0);
    wait_tx(d, got);
    rx_send(mk(1'b0, 4'h2, 3'b001, 3'd2));
    chk("mism_busy", 32'(busy), 1);
    rx_send(mk(1'b0, 4'h2, 3'b010, 3'd1));
    wait_done(st, got);
    chk("nak_status", 32'(st), 1);
    chk("nak_cur_width", 32'(cur_width), 4);
    step();

    // Back-pressure holds the DLLP stable; then reset during WAIT_RSP.
    tx_dllp_ready = 1'b0;
    local_req(3'd3, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("stall_valid", 32'(tx_dllp_valid), 1);
      chk("stall_data", tx_dllp_data, 32'h2800_8803);
      step();
    end
    tx_dllp_ready = 1'b1;
    wait_tx(d, got);
    chk("stall_release_data", d, 32'h2800_8803);
    step();
    chk("stall_waiting", 32'(busy), 1);
    n0 = tx_dat_q.size();
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_cur_width", 32'(cur_width), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_tx_valid", 32'(tx_dllp_valid), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_done_status", 32'(done_status), 0);
    step();
    step();
    rst = 1'b0;
    repeat (3 * TMO) step();
    chk("post_rst_no_tx", 32'(tx_dat_q.size() - n0), 0);
    chk("post_rst_idle", 32'(busy), 0);

    // Randomized traffic against the transaction-level model.
    exp_cur = 0;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      w    = $urandom_range(0, 7);
      mx   = $urandom_range(0, 4);
      p    = 1'($urandom_range(0, 1));
      max_width = 3'(mx);
      n0 = tx_dat_q.size();
      d0 = done_cnt;
      if (kind == 0) begin
        local_req(3'(w), p);
        if (!legal(w, mx)) begin
          wait_done(st, got);
          chk("rnd_refuse_status", 32'(st), 1);
          chk("rnd_refuse_no_tx", 32'(tx_dat_q.size() - n0), 0);
        end else begin
          wait_tx(d, got);
          chk("rnd_req_data", d, mk(p, 4'h1, 3'b000, 3'(w)));
          r = $urandom_range(0, 2);
          if (r == 2) begin
            rx_send(mk(1'b0, 4'h2, 3'b001, 3'((w + 1) % 8)));
            chk("rnd_mism_busy", 32'(busy), 1);
            r = 0;
          end
          rx_send(mk(1'b0, 4'h2, (r == 0) ? 3'b001 : 3'b010, 3'(w)));
          exp_st = (r == 0) ? 0 : 1;
          if (r == 0) exp_cur = w;
          wait_done(st, got);
          chk("rnd_rsp_status", 32'(st), 32'(exp_st));
        end
        chk("rnd_local_cur", 32'(cur_width), 32'(exp_cur));
      end else if (kind == 1) begin
        rx_send(mk(p, 4'h1, 3'b000, 3'(w)));
        wait_tx(d, got);
        chk("rnd_reply_data", d,
            mk(p, 4'h2, legal(w, mx) ? 3'b001 : 3'b010, 3'(w)));
        if (legal(w, mx)) exp_cur = w;
        chk("rnd_remote_cur", 32'(cur_width), 32'(exp_cur));
        chk("rnd_remote_no_done", 32'(done_cnt - d0), 0);
      end else begin
        d = mk(p, 4'h1, 3'b000, 3'(w));
        if (p) d[31:24] = 8'h29;
        else   d[14:11] = 4'h3;
        rx_send(d);
        step();
        chk("rnd_junk_idle", 32'(busy), 0);
        chk("rnd_junk_no_tx", 32'(tx_dat_q.size() - n0), 0);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
